div_unit: RTL and testbench

Multi-cycle radix-2 integer divider in the EX stage of the 5-stage MIPS pipeline. Executes DIV/DIVU and drives `div_stallE` into the hazard unit, which freezes F/D/E/M/W while the division runs. Delivers quotient (LO) and remainder (HI) to the EX result path. Holds the result until the EX-stage instruction actually advances.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_unit.sv | 153 +++++++++++++++
 tb/tb_div_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the EX-stage integer divider.
//   div_state_t  : divider FSM states
//   DIV_CYCLES   : restoring steps per 32-bit division
//   DIV_ZERO_LO  : quotient returned for a zero divisor
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int unsigned DIV_CYCLES  = 32;
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Stalls the pipeline while dividing, then holds the result until EX advances.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   div_enE            : EX instruction is DIV/DIVU
//   div_signedE        : 1 = signed DIV, 0 = DIVU
//   src_aE, src_bE     : dividend, divisor (after forwarding)
//   stallE, flushE     : EX stall / flush from the hazard unit
//   div_stallE         : pipeline stall request (combinational)
//   div_ready          : result valid (FSM in DONE)
//   hiE, loE           : remainder, quotient
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_enE,
    input  logic             div_signedE,
    input  logic [WIDTH-1:0] src_aE,
    input  logic [WIDTH-1:0] src_bE,
    input  logic             stallE,
    input  logic             flushE,
    output logic             div_stallE,
    output logic             div_ready,
    output logic [WIDTH-1:0] hiE,
    output logic [WIDTH-1:0] loE
);

    localparam int unsigned    CYCLES  = (WIDTH == 32) ? DIV_CYCLES : WIDTH;
    localparam int unsigned    CNT_W   = $clog2(CYCLES);
    localparam logic [WIDTH-1:0] ZERO_LO = (WIDTH == 32) ? WIDTH'(DIV_ZERO_LO) : {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? f_neg(x) : x;
    endfunction

    div_state_t       r_state, w_state_next;
    logic [WIDTH-1:0] r_q, w_q_next;
    logic [WIDTH-1:0] r_rem, w_rem_next;
    logic [WIDTH-1:0] r_b, w_b_next;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic             r_q_neg, w_q_neg_next;
    logic             r_r_neg, w_r_neg_next;
    logic [WIDTH-1:0] r_hi, w_hi_next;
    logic [WIDTH-1:0] r_lo, w_lo_next;
    logic             r_ready;

    // One restoring step; the shifted remainder needs WIDTH+1 bits for large divisors.
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_q_step;

    assign w_shift    = {r_rem, r_q[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_b});
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_rem_step = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_q_step   = {r_q[WIDTH-2:0], w_ge};

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_rem   <= '0;
            r_b     <= '0;
            r_count <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_rem   <= w_rem_next;
            r_b     <= w_b_next;
            r_count <= w_count_next;
            r_q_neg <= w_q_neg_next;
            r_r_neg <= w_r_neg_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_ready <= (w_state_next == DONE);
        end
    end

    // Next-state and datapath update; flush abandons work and keeps old hi/lo
    always_comb begin
        w_state_next  = r_state;
        w_q_next      = r_q;
        w_rem_next    = r_rem;
        w_b_next      = r_b;
        w_count_next  = r_count;
        w_q_neg_next  = r_q_neg;
        w_r_neg_next  = r_r_neg;
        w_hi_next     = r_hi;
        w_lo_next     = r_lo;

        unique case (r_state)
            IDLE: begin
                if (div_enE && !flushE) begin
                    w_q_next     = f_abs(src_aE, div_signedE);
                    w_b_next     = f_abs(src_bE, div_signedE);
                    w_q_neg_next = div_signedE & (src_aE[WIDTH-1] ^ src_bE[WIDTH-1]);
                    w_r_neg_next = div_signedE & src_aE[WIDTH-1];
                    w_rem_next   = '0;
                    w_count_next = '0;
                    if (src_bE == '0) begin
                        w_lo_next    = ZERO_LO;
                        w_hi_next    = src_aE;
                        w_state_next = DONE;
                    end else begin
                        w_state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (flushE) begin
                    w_state_next = IDLE;
                end else begin
                    w_q_next     = w_q_step;
                    w_rem_next   = w_rem_step;
                    w_count_next = r_count + CNT_W'(1);
                    if (r_count == CNT_W'(CYCLES - 1)) begin
                        w_lo_next    = r_q_neg ? f_neg(w_q_step) : w_q_step;
                        w_hi_next    = r_r_neg ? f_neg(w_rem_step) : w_rem_step;
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (flushE || !stallE) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Independent of stallE so there is no loop through the hazard unit
    assign div_stallE = div_enE & ~flushE & (r_state != DONE);
    assign div_ready  = r_ready;
    assign hiE        = r_hi;
    assign loE        = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// Directed + scoreboard testbench for div_unit.
module tb_div_unit;
    import div_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         div_enE;
    logic         div_signedE;
    logic [W-1:0] src_aE;
    logic [W-1:0] src_bE;
    logic         stallE;
    logic         flushE;
    logic         div_stallE;
    logic         div_ready;
    logic [W-1:0] hiE;
    logic [W-1:0] loE;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] sb_q[$];

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_enE    (div_enE),
        .div_signedE(div_signedE),
        .src_aE     (src_aE),
        .src_bE     (src_bE),
        .stallE     (stallE),
        .flushE     (flushE),
        .div_stallE (div_stallE),
        .div_ready  (div_ready),
        .hiE        (hiE),
        .loE        (loE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour written directly from the architectural definition
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         output logic [W-1:0] lo, output logic [W-1:0] hi);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == '0) begin
            lo = DIV_ZERO_LO;
            hi = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = '0;
        end else if (sgn) begin
            lo = W'(sa / sb);
            hi = W'(sa % sb);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    // Issue one divide, wait for DONE, compare against the scoreboard, then retire
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                           input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi, input int hold);
        logic [2*W-1:0] e;
        int n_stall;
        bit done;
        n_stall = 0;
        done    = 1'b0;
        sb_q.push_back({exp_lo, exp_hi});
        src_aE      = a;
        src_bE      = b;
        div_signedE = sgn;
        flushE      = 1'b0;
        stallE      = (hold > 0);
        div_enE     = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (div_ready) begin
                done = 1'b1;
                break;
            end
            if (div_stallE) n_stall++;
            tick();
        end
        e = sb_q.pop_front();
        chk("done_reached", W'(done), W'(1));
        if (!done) begin
            div_enE = 1'b0;
            stallE  = 1'b0;
            return;
        end
        chk("lo", loE, e[2*W-1:W]);
        chk("hi", hiE, e[W-1:0]);
        chk("stall_cycles", W'(n_stall), (b == '0) ? W'(1) : W'(DIV_CYCLES + 1));
        chk("stall_in_done", W'(div_stallE), W'(0));
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_ready", W'(div_ready), W'(1));
            chk("hold_stall", W'(div_stallE), W'(0));
            chk("hold_lo", loE, e[2*W-1:W]);
            chk("hold_hi", hiE, e[W-1:0]);
        end
        stallE = 1'b0;
        tick();
        div_enE = 1'b0;
        #1;
        chk("idle_ready", W'(div_ready), W'(0));
        chk("idle_stall", W'(div_stallE), W'(0));
    endtask

    initial begin
        logic [W-1:0] ra, rb, rlo, rhi;
        logic         rs;

        rst         = 1'b1;
        div_enE     = 1'b0;
        div_signedE = 1'b0;
        src_aE      = '0;
        src_bE      = '0;
        stallE      = 1'b0;
        flushE      = 1'b0;
        #1;
        chk("rst_lo", loE, '0);
        chk("rst_hi", hiE, '0);
        chk("rst_ready", W'(div_ready), W'(0));
        chk("rst_stall", W'(div_stallE), W'(0));
        tick();
        tick();
        rst = 1'b0;

        run_div(32'd7, 32'd2, 1'b0, 32'd3, 32'd1, 0);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 0);
        run_div(32'd5, 32'd0, 1'b0, DIV_ZERO_LO, 32'd5, 0);
        run_div(32'hFFFF_FFFB, 32'd0, 1'b1, DIV_ZERO_LO, 32'hFFFF_FFFB, 0);
        run_div(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd1, 32'h7FFF_FFFF, 0);
        run_div(32'd100, 32'd9, 1'b0, 32'd11, 32'd1, 3);

        // Flush during BUSY cycle 10 keeps the previous result
        run_div(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 0);
        src_aE      = 32'd50;
        src_bE      = 32'd9;
        div_signedE = 1'b0;
        div_enE     = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        flushE = 1'b1;
        #1;
        chk("flush_stall", W'(div_stallE), W'(0));
        tick();
        flushE  = 1'b0;
        div_enE = 1'b0;
        #1;
        chk("flush_ready", W'(div_ready), W'(0));
        chk("flush_lo_kept", loE, 32'd333);
        chk("flush_hi_kept", hiE, 32'd1);
        run_div(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 0);

        // Flush together with start: nothing may begin, so the next op sees full latency
        src_aE  = 32'd9;
        src_bE  = 32'd2;
        div_enE = 1'b1;
        flushE  = 1'b1;
        #1;
        chk("flush_start_stall", W'(div_stallE), W'(0));
        tick();
        flushE = 1'b0;
        run_div(32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 0);

        // Asynchronous reset in the middle of BUSY
        src_aE      = 32'd100;
        src_bE      = 32'd7;
        div_signedE = 1'b0;
        div_enE     = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_lo", loE, '0);
        chk("arst_hi", hiE, '0);
        chk("arst_ready", W'(div_ready), W'(0));
        chk("arst_stall", W'(div_stallE), W'(1));
        div_enE = 1'b0;
        tick();
        rst = 1'b0;
        run_div(32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 0);

        // Random operands against the reference model
        for (int n = 0; n < 4; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (n[0]) rb = rb >> $urandom_range(8, 28);
            if (rb == '0) rb = 32'd3;
            model(ra, rb, rs, rlo, rhi);
            run_div(ra, rb, rs, rlo, rhi, 0);
        end

        chk("scoreboard_empty", W'(sb_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
